// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: control handshake, PC load port and instruction-memory bus.
// The fetch unit takes the slave side; control plus memory take the master side.
interface instr_fetch_if #(
  parameter int PC_WIDTH = 16
);
  logic                fetch_req;
  logic                pc_load;
  logic [PC_WIDTH-1:0] pc_load_val;
  logic [PC_WIDTH-1:0] pc;
  logic                im_read;
  logic [15:0]         instr_in;
  logic [15:0]         instr_out;
  logic                instr_valid;
  logic                busy;
  logic                fetch_err;

  modport master (
    output fetch_req, pc_load, pc_load_val, instr_in,
    input  pc, im_read, instr_out, instr_valid, busy, fetch_err
  );

  modport slave (
    input  fetch_req, pc_load, pc_load_val, instr_in,
    output pc, im_read, instr_out, instr_valid, busy, fetch_err
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch initiator: owns the PC, issues one im_read per fetch,
// waits MEM_LATENCY cycles, latches the word and advances or redirects the PC.
module instr_fetch #(
  parameter int                  PC_WIDTH    = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  MEM_LATENCY = 1,
  parameter int                  PC_LIMIT    = 32
) (
  input  logic         clk,
  input  logic         rst,
  instr_fetch_if.slave bus
);
  localparam int                  CW      = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [PC_WIDTH-1:0] PC_MASK = PC_WIDTH'(PC_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       wait_cnt;
  logic                last_wait;
  logic                capture;
  logic [PC_WIDTH-1:0] load_tgt, pc_inc, pc_nxt, pend_pc;
  logic                pend_vld;

  assign last_wait = (state == WAIT) && (wait_cnt == CW'(MEM_LATENCY - 1));
  assign load_tgt  = {bus.pc_load_val[PC_WIDTH-1:1], 1'b0} & PC_MASK;
  assign pc_inc    = (bus.pc + PC_WIDTH'(2)) & PC_MASK;
  // A load landing on the capture edge itself wins over any older pending one.
  assign pc_nxt    = bus.pc_load ? load_tgt : (pend_vld ? pend_pc : pc_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.fetch_req) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (last_wait) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    capture  = last_wait;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pc          <= RESET_PC;
      bus.im_read     <= 1'b0;
      bus.instr_out   <= 16'h0000;
      bus.instr_valid <= 1'b0;
      bus.fetch_err   <= 1'b0;
      pend_vld        <= 1'b0;
      pend_pc         <= '0;
      wait_cnt        <= '0;
    end else begin
      bus.im_read     <= (state_nxt == REQ);
      bus.instr_valid <= capture;
      wait_cnt        <= (state == WAIT && !last_wait) ? wait_cnt + CW'(1) : '0;
      if (bus.pc_load && bus.pc_load_val[0]) bus.fetch_err <= 1'b1;
      if (capture) begin
        bus.instr_out <= bus.instr_in;
        bus.pc        <= pc_nxt;
        pend_vld      <= 1'b0;
      end else if (state == IDLE) begin
        if (bus.pc_load) bus.pc <= load_tgt;
      end else if (bus.pc_load) begin
        // PC must stay stable for the in-flight fetch; park the target.
        pend_pc  <= load_tgt;
        pend_vld <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: byte memory model, vector table plus scoreboard of
// expected fetches checked when im_read / instr_valid appear.
module tb_instr_fetch;
  localparam int          PW  = 16;
  localparam logic [15:0] RPC = 16'h0000;
  localparam int          LAT = 1;
  localparam int          LIM = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if #(.PC_WIDTH(PW)) bus();

  instr_fetch #(.PC_WIDTH(PW), .RESET_PC(RPC), .MEM_LATENCY(LAT), .PC_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  logic [7:0] mem [LIM];
  always @(posedge clk)
    if (bus.im_read) bus.instr_in <= {mem[(int'(bus.pc) + 1) % LIM], mem[int'(bus.pc) % LIM]};

  typedef struct {
    logic [15:0] fpc;
    logic [15:0] word;
    int          vcyc;
  } exp_t;

  typedef struct {
    logic        pre_load;
    logic [15:0] pre_val;
    logic        co_load;
    logic [15:0] co_val;
    int          busy_load;  // 0 none, 1 during REQ, 2 during WAIT
    logic [15:0] bval;
    logic [15:0] fpc;
    logic [15:0] word;
    logic [15:0] npc;
    logic        err;
  } vec_t;

  exp_t q[$];
  vec_t vt[8];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_rd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.im_read) begin
      if (prev_rd) begin
        errors++;
        $display("FAIL im_read_width: strobe high for more than one cycle");
      end
      if (q.size() == 0) begin
        errors++;
        $display("FAIL im_read_unexpected: strobe with pc %0h", bus.pc);
      end else chk("im_read_pc", bus.pc, q[0].fpc);
    end
    prev_rd = bus.im_read;
    if (bus.instr_valid) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL valid_unexpected: instr_out %0h", bus.instr_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("instr_out", bus.instr_out, e.word);
        chk("valid_cycle", cyc, e.vcyc);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 20) begin step(); t++; end
    if (bus.busy) begin
      errors++;
      $display("FAIL idle_timeout: busy still %0b", bus.busy);
    end
  endtask

  task automatic wait_drain(input logic [15:0] npc, input logic err);
    int t = 0;
    while (q.size() != 0 && t < 20) begin step(); t++; end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL valid_timeout: %0d fetches outstanding, expected 0", q.size());
      q.delete();
    end
    chk("next_pc", bus.pc, npc);
    chk("fetch_err", bus.fetch_err, err);
  endtask

  task automatic apply(input vec_t v);
    wait_idle();
    if (v.pre_load) begin
      bus.pc_load = 1'b1; bus.pc_load_val = v.pre_val;
      step();
      bus.pc_load = 1'b0;
    end
    bus.fetch_req = 1'b1; bus.pc_load = v.co_load; bus.pc_load_val = v.co_val;
    q.push_back('{v.fpc, v.word, cyc + LAT + 2});
    step();
    bus.fetch_req = 1'b0; bus.pc_load = 1'b0;
    chk("busy_req", bus.busy, 1);
    if (v.busy_load != 0) begin
      if (v.busy_load == 2) step();
      bus.pc_load = 1'b1; bus.pc_load_val = v.bval;
      step();
      bus.pc_load = 1'b0;
    end
    wait_drain(v.npc, v.err);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, bus.pc, RPC);
    chk({tag, "_im_read"}, bus.im_read, 0);
    chk({tag, "_instr_out"}, bus.instr_out, 0);
    chk({tag, "_valid"}, bus.instr_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_err"}, bus.fetch_err, 0);
  endtask

  initial begin
    for (int i = 0; i < LIM; i++) mem[i] = 8'(8'h10 + i);
    mem[0] = 8'hC3; mem[1] = 8'hA5;

    //            pre  pval    co   cval    bl bval     fpc      word      npc      err
    vt[0] = '{1'b0, 16'h0, 1'b0, 16'h0, 0, 16'h0,  16'h0000, 16'hA5C3, 16'h0002, 1'b0};
    vt[1] = '{1'b0, 16'h0, 1'b0, 16'h0, 0, 16'h0,  16'h0002, 16'h1312, 16'h0004, 1'b0};
    vt[2] = '{1'b0, 16'h0, 1'b0, 16'h0, 2, 16'h0C, 16'h0004, 16'h1514, 16'h000C, 1'b0};
    vt[3] = '{1'b0, 16'h0, 1'b0, 16'h0, 1, 16'h14, 16'h000C, 16'h1D1C, 16'h0014, 1'b0};
    vt[4] = '{1'b0, 16'h0, 1'b1, 16'h8, 0, 16'h0,  16'h0008, 16'h1918, 16'h000A, 1'b0};
    vt[5] = '{1'b1, 16'h1E,1'b0, 16'h0, 0, 16'h0,  16'h001E, 16'h2F2E, 16'h0000, 1'b0};
    vt[6] = '{1'b0, 16'h0, 1'b1, 16'h7, 0, 16'h0,  16'h0006, 16'h1716, 16'h0008, 1'b1};
    vt[7] = '{1'b0, 16'h0, 1'b0, 16'h0, 0, 16'h0,  16'h0008, 16'h1918, 16'h000A, 1'b1};

    rst = 1'b1;
    bus.fetch_req = 1'b0; bus.pc_load = 1'b0; bus.pc_load_val = '0;
    #2;
    chk_reset("reset");
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) apply(vt[i]);

    // Back-to-back fetches with fetch_req held high, starting from pc 0.
    bus.pc_load = 1'b1; bus.pc_load_val = 16'h0000;
    step();
    bus.pc_load = 1'b0;
    bus.fetch_req = 1'b1;
    q.push_back('{16'h0000, 16'hA5C3, cyc + LAT + 2});
    q.push_back('{16'h0002, 16'h1312, cyc + 2 * (LAT + 2)});
    q.push_back('{16'h0004, 16'h1514, cyc + 3 * (LAT + 2)});
    repeat (7) step();
    bus.fetch_req = 1'b0;
    wait_drain(16'h0006, 1'b1);

    // Reset in WAIT aborts the fetch and clears the sticky error.
    bus.fetch_req = 1'b1;
    q.push_back('{16'h0006, 16'h1716, cyc + LAT + 2});
    step();
    bus.fetch_req = 1'b0;
    step();
    rst = 1'b1;
    #1;
    q.delete();
    chk_reset("abort");
    repeat (3) step();
    rst = 1'b0;
    step();
    apply(vt[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
